mdu_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit with its own sequencing FSM. Sits beside the ALU in the

---
 rtl/mdu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV32M multiply/divide unit with its own sequencing FSM
// Shared shift-add multiplier / restoring divider, fixed XLEN+2 cycle latency for every op.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            exdone_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic              neg_q, neg_d;
  logic              sa_q, sa_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   fix_val;

  // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both, all others unsigned.
  always_comb begin
    is_div   = func3_i[2];
    a_signed = is_div ? ~func3_i[0] : (func3_i[1:0] == 2'b01 || func3_i[1:0] == 2'b10);
    b_signed = is_div ? ~func3_i[0] : (func3_i[1:0] == 2'b01);
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
  end

  // hi/lo hold the product accumulator for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod      = {hi_q, lo_q};
    prod_s    = neg_q ? -prod : prod;
  end

  // A zero divisor leaves quotient all ones and remainder |rs1|, so only the quotient needs forcing.
  always_comb begin
    fix_val = '0;
    if (!func3_q[2]) begin
      fix_val = (func3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (!func3_q[1]) begin
      fix_val = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
    end else begin
      fix_val = sa_q ? -hi_q : hi_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = S_CALC;
          cnt_d   = CW'(XLEN - 1);
          func3_d = func3_i;
          neg_d   = a_neg ^ b_neg;
          sa_d    = a_neg;
          div0_d  = (rs2_i == '0);
          hi_d    = '0;
          lo_d    = is_div ? a_mag : b_mag;
          opb_d   = is_div ? b_mag : a_mag;
        end
      end
      S_CALC: begin
        if (func3_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign exdone_o = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_mdu_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i, flush_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] rs1_i, rs2_i;
  logic            busy_o, exdone_o;
  logic [XLEN-1:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .func3_i  (func3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .exdone_o (exdone_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; lat is the cycle index (accept edge = N) in which exdone is seen, -1 on timeout.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    int  i;
    bit  seen;
    start_i = 1'b1; func3_i = f; rs1_i = a; rs2_i = b;
    tick();
    start_i = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
    lat  = -1;
    res  = 'x;
    seen = 1'b0;
    i    = 0;
    while (!seen && i < 100) begin
      if (exdone_o) begin
        seen = 1'b1;
        lat  = i + 1;
        res  = result_o;
      end else begin
        tick();
        i++;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r;
    int          lat;
    do_op(tag, f, a, b, r, lat);
    check_eq(tag, r, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(XLEN + 2));
    tick();
  endtask

  initial begin
    logic [31:0] r;
    int          lat, pulses;

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; func3_i = '0; rs1_i = '0; rs2_i = '0;
    tick(); tick();
    check_eq("rst_busy",   32'(busy_o),   32'd0);
    check_eq("rst_exdone", 32'(exdone_o), 32'd0);
    check_eq("rst_result", result_o,      32'd0);
    rst_n = 1'b1;
    tick();

    op_check("mul_7x-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    op_check("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    op_check("mulhu_ones",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_check("mulhsu_ones",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op_check("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    op_check("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    op_check("div_-7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    op_check("rem_-7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    op_check("divu_0",       3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF);
    op_check("remu_0",       3'b111, 32'h1234,     32'd0,        32'h00001234);
    op_check("div_-5_0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    op_check("rem_-5_0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    op_check("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14);
    op_check("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2);

    // start re-asserted during CALC and during DONE must be ignored
    start_i = 1'b1; func3_i = 3'b000; rs1_i = 32'd5; rs2_i = 32'd6;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    start_i = 1'b1; func3_i = 3'b100; rs1_i = 32'd100; rs2_i = 32'd3;
    tick();
    start_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60 && pulses == 0; i++) begin
      if (exdone_o) pulses++;
      else tick();
    end
    check_eq("ign_result", result_o, 32'd30);
    start_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd9; rs2_i = 32'd2;
    tick();
    start_i = 1'b0;
    check_eq("ign_done_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 60; i++) begin
      if (exdone_o) pulses++;
      tick();
    end
    check_eq("ign_pulses", 32'(pulses), 32'd1);
    check_eq("ign_result_held", result_o, 32'd30);

    // flush at CALC cycle 10: no exdone, result unchanged
    start_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_eq("flush_busy", 32'(busy_o), 32'd0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (exdone_o) pulses++;
      tick();
    end
    check_eq("flush_pulses", 32'(pulses), 32'd0);
    check_eq("flush_result", result_o, 32'd30);

    // flush together with start in IDLE: no accept
    start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_start_busy", 32'(busy_o), 32'd0);

    // asynchronous reset mid-CALC
    start_i = 1'b1; func3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy",   32'(busy_o),   32'd0);
    check_eq("arst_exdone", 32'(exdone_o), 32'd0);
    check_eq("arst_result", result_o,      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("mul_3x4", 3'b000, 32'd3, 32'd4, r, lat);
    check_eq("mul_3x4", r, 32'd12);
    check_eq("mul_3x4_lat", 32'(lat), 32'(XLEN + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
